// File: rtl/cs_addsub_pipe.sv
// Two-stage pipelined carry-select add/subtract unit with valid/ready handshake.
// Stage 1 precomputes every upper segment for both carry-ins; stage 2 ripples the select chain.
module cs_addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int NSEG = WIDTH / SEG;

  // Global pipeline enable: the whole pipe advances unless a result is waiting on a stalled sink.
  logic en;
  logic accept;

  assign en       = !out_valid | out_ready;
  assign in_ready = en;
  assign accept   = in_valid & en;

  // Subtraction is folded into addition of the inverted operand with an inverted borrow.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign b_eff   = mode ? ~b : b;
  assign cin_eff = mode ? ~c_in : c_in;

  // ---------------------------------------------------------------
  // Stage 1 combinational: per-segment sums
  // ---------------------------------------------------------------
  logic [SEG:0]                 seg0_full;
  logic [NSEG-1:1][SEG-1:0]     sum0_next;
  logic [NSEG-1:1][SEG-1:0]     sum1_next;
  logic [NSEG-1:1]              carry0_next;
  logic [NSEG-1:1]              carry1_next;

  assign seg0_full = {1'b0, a[SEG-1:0]} + {1'b0, b_eff[SEG-1:0]} + {{SEG{1'b0}}, cin_eff};

  generate
    for (genvar gi = 1; gi < NSEG; gi++) begin : g_seg_pre
      logic [SEG:0] full0;
      logic [SEG:0] full1;

      assign full0 = {1'b0, a[gi*SEG +: SEG]} + {1'b0, b_eff[gi*SEG +: SEG]};
      assign full1 = {1'b0, a[gi*SEG +: SEG]} + {1'b0, b_eff[gi*SEG +: SEG]}
                     + {{SEG{1'b0}}, 1'b1};

      assign sum0_next[gi]   = full0[SEG-1:0];
      assign carry0_next[gi] = full0[SEG];
      assign sum1_next[gi]   = full1[SEG-1:0];
      assign carry1_next[gi] = full1[SEG];
    end
  endgenerate

  // ---------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------
  logic                     s1_valid_reg;
  logic [SEG-1:0]           s1_seg0_sum_reg;
  logic                     s1_seg0_carry_reg;
  logic [NSEG-1:1][SEG-1:0] s1_sum0_reg;
  logic [NSEG-1:1][SEG-1:0] s1_sum1_reg;
  logic [NSEG-1:1]          s1_carry0_reg;
  logic [NSEG-1:1]          s1_carry1_reg;
  logic                     s1_a_msb_reg;
  logic                     s1_b_msb_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg      <= 1'b0;
      s1_seg0_sum_reg   <= '0;
      s1_seg0_carry_reg <= 1'b0;
      s1_sum0_reg       <= '0;
      s1_sum1_reg       <= '0;
      s1_carry0_reg     <= '0;
      s1_carry1_reg     <= '0;
      s1_a_msb_reg      <= 1'b0;
      s1_b_msb_reg      <= 1'b0;
    end else if (en) begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_seg0_sum_reg   <= seg0_full[SEG-1:0];
        s1_seg0_carry_reg <= seg0_full[SEG];
        s1_sum0_reg       <= sum0_next;
        s1_sum1_reg       <= sum1_next;
        s1_carry0_reg     <= carry0_next;
        s1_carry1_reg     <= carry1_next;
        s1_a_msb_reg      <= a[WIDTH-1];
        s1_b_msb_reg      <= b_eff[WIDTH-1];
      end
    end
  end

  // ---------------------------------------------------------------
  // Stage 2 combinational: carry-select chain
  // ---------------------------------------------------------------
  logic [NSEG:1]    carry_sel;
  logic [WIDTH-1:0] sum_next;
  logic             c_out_next;
  logic             ovf_next;
  logic             zero_next;

  assign carry_sel[1]       = s1_seg0_carry_reg;
  assign sum_next[SEG-1:0]  = s1_seg0_sum_reg;

  generate
    for (genvar gi = 1; gi < NSEG; gi++) begin : g_seg_sel
      assign sum_next[gi*SEG +: SEG] = carry_sel[gi] ? s1_sum1_reg[gi] : s1_sum0_reg[gi];
      assign carry_sel[gi+1]         = carry_sel[gi] ? s1_carry1_reg[gi] : s1_carry0_reg[gi];
    end
  endgenerate

  // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
  assign c_out_next = carry_sel[NSEG];
  assign ovf_next   = sum_next[WIDTH-1] ^ s1_a_msb_reg ^ s1_b_msb_reg ^ c_out_next;
  assign zero_next  = ~|sum_next;

  // ---------------------------------------------------------------
  // Stage 2 registers / outputs
  // ---------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid_reg;
      // Bubbles leave the last result on the bus rather than loading stale stage-1 data.
      if (s1_valid_reg) begin
        sum   <= sum_next;
        c_out <= c_out_next;
        ovf   <= ovf_next;
        zero  <= zero_next;
      end
    end
  end

endmodule

// File: tb/tb_cs_addsub_pipe.sv
// Scoreboard bench for cs_addsub_pipe: a 16/4 and an 8/2 instance share one stimulus stream.
// Expected {zero, ovf, c_out, sum} is queued on each accepted beat and popped on each output beat.
module tb_cs_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        mode;
  logic        out_ready;

  logic        in_ready16, out_valid16, c_out16, ovf16, zero16;
  logic [15:0] sum16;
  logic        in_ready8, out_valid8, c_out8, ovf8, zero8;
  logic [7:0]  sum8;

  always #5 clk = ~clk;

  cs_addsub_pipe #(.WIDTH(16), .SEG(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
    .a(a), .b(b), .c_in(c_in), .mode(mode),
    .out_valid(out_valid16), .out_ready(out_ready),
    .sum(sum16), .c_out(c_out16), .ovf(ovf16), .zero(zero16)
  );

  cs_addsub_pipe #(.WIDTH(8), .SEG(2)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .a(a[7:0]), .b(b[7:0]), .c_in(c_in), .mode(mode),
    .out_valid(out_valid8), .out_ready(out_ready),
    .sum(sum8), .c_out(c_out8), .ovf(ovf8), .zero(zero8)
  );

  typedef struct {
    longint exp;
    int     cyc;
  } ent_t;

  ent_t   q16[$];
  ent_t   q8[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc   = 0;
  int     n_out16 = 0;
  bit     acc;
  bit     lat_chk = 1'b0;
  bit     verbose = 1'b1;
  bit     stall16 = 1'b0;
  bit     stall8  = 1'b0;
  bit     saw_stall = 1'b0;
  longint prev16, prev8;
  longint ovr16 = -1;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: signed overflow judged from the ideal signed result, not from carries.
  function automatic longint model(input longint av, input longint bv, input bit ci,
                                   input bit md, input int w);
    longint m, full, sa, sb, ideal, s, co, ov, z, half;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    av   = av & m;
    bv   = bv & m;
    full = md ? av + ((~bv) & m) + (ci ? 0 : 1) : av + bv + longint'(ci);
    s    = full & m;
    co   = (full >> w) & 1;
    sa   = (av >= half) ? av - (longint'(1) << w) : av;
    sb   = (bv >= half) ? bv - (longint'(1) << w) : bv;
    ideal = md ? sa - sb - longint'(ci) : sa + sb + longint'(ci);
    ov   = (ideal > half - 1 || ideal < -half) ? 1 : 0;
    z    = (s == 0) ? 1 : 0;
    return (z << (w + 2)) | (ov << (w + 1)) | (co << w) | s;
  endfunction

  // One clock: observe at the falling edge, then return just after the next rising edge.
  task automatic step();
    ent_t   e;
    longint o16, o8;
    @(negedge clk);
    cyc++;
    acc = 1'b0;
    o16 = longint'({zero16, ovf16, c_out16, sum16});
    o8  = longint'({zero8, ovf8, c_out8, sum8});
    if (rst) begin
      q16.delete();
      q8.delete();
      stall16 = 1'b0;
      stall8  = 1'b0;
    end else begin
      check("in_ready16", in_ready16, !out_valid16 || out_ready);
      check("in_ready8", in_ready8, !out_valid8 || out_ready);
      if (!in_ready16) saw_stall = 1'b1;
      if (stall16) check("hold16", o16, prev16);
      if (stall8)  check("hold8", o8, prev8);
      if (out_valid16 && out_ready) begin
        n_out16++;
        if (q16.size() == 0) check("spurious16", out_valid16, 0);
        else begin
          e = q16.pop_front();
          check("res16", o16, e.exp);
          if (lat_chk) check("lat16", cyc - e.cyc, 2);
          if (verbose) $display("txn w16 cyc=%0d sum=%h c=%b v=%b z=%b", cyc, sum16, c_out16, ovf16, zero16);
        end
      end
      if (out_valid8 && out_ready) begin
        if (q8.size() == 0) check("spurious8", out_valid8, 0);
        else begin
          e = q8.pop_front();
          check("res8", o8, e.exp);
          if (lat_chk) check("lat8", cyc - e.cyc, 2);
          if (verbose) $display("txn w8  cyc=%0d sum=%h c=%b v=%b z=%b", cyc, sum8, c_out8, ovf8, zero8);
        end
      end
      stall16 = out_valid16 && !out_ready;
      stall8  = out_valid8 && !out_ready;
      prev16  = o16;
      prev8   = o8;
      if (in_valid && in_ready16) begin
        acc = 1'b1;
        q16.push_back('{(ovr16 >= 0) ? ovr16 : model(a, b, c_in, mode, 16), cyc});
      end
      if (in_valid && in_ready8) q8.push_back('{model(a, b, c_in, mode, 8), cyc});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] av, input logic [15:0] bv, input bit ci,
                      input bit md, input longint e16);
    in_valid = 1'b1;
    a = av; b = bv; c_in = ci; mode = md;
    ovr16 = e16;
    for (int k = 0; k < 50; k++) begin
      step();
      if (acc) break;
    end
    if (!acc) check("send_timeout", acc, 1);
    in_valid = 1'b0;
    ovr16 = -1;
  endtask

  task automatic drain(input int budget);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < budget; k++) begin
      if (q16.size() == 0 && q8.size() == 0) break;
      step();
    end
    check("drain16", q16.size(), 0);
    check("drain8", q8.size(), 0);
  endtask

  initial begin
    int sent, base_out, guard;

    // Reset held with a beat offered: nothing may leak into the pipe.
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    a = 16'h1111; b = 16'h2222; c_in = 1'b0; mode = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_valid16", out_valid16, 0);
      check("rst_out16", {zero16, ovf16, c_out16, sum16}, 0);
      check("rst_valid8", out_valid8, 0);
      check("rst_out8", {zero8, ovf8, c_out8, sum8}, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("ready_after_rst16", in_ready16, 1);
    check("ready_after_rst8", in_ready8, 1);
    check("no_leak16", out_valid16, 0);
    @(posedge clk); #1;

    // Directed boundary cases, back to back, with latency checked.
    out_ready = 1'b1;
    lat_chk   = 1'b1;
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, 64'h0_0100);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 64'h5_0000);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 64'h2_8000);
    send(16'h0005, 16'h0007, 1'b0, 1'b1, 64'h0_FFFE);
    send(16'h1234, 16'h1234, 1'b0, 1'b1, 64'h5_0000);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, -1);
    send(16'h0000, 16'h0000, 1'b1, 1'b1, -1);
    send(16'h8080, 16'h8080, 1'b1, 1'b0, -1);
    drain(10);
    lat_chk = 1'b0;

    // Backpressure: four beats, sink stalled in cycles 3..5.
    sent = 0;
    saw_stall = 1'b0;
    base_out = n_out16;
    for (int t = 0; t < 20; t++) begin
      in_valid  = (sent < 4);
      a         = 16'h0100 * (sent + 1) + 16'h00F0;
      b         = 16'h0031 + 16'(sent);
      c_in      = sent[0];
      mode      = sent[1];
      out_ready = !(t >= 3 && t <= 5);
      step();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    drain(10);
    check("bp_sent", sent, 4);
    check("bp_emerged", n_out16 - base_out, 4);
    check("bp_stall_seen", saw_stall, 1);

    // Random traffic with a reset pulse in the middle.
    verbose = 1'b0;
    sent  = 0;
    guard = 0;
    while (sent < 10000 && guard < 60000) begin
      guard++;
      if (sent == 5000 && !rst) begin
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
      end
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      a         = 16'($urandom);
      b         = 16'($urandom);
      c_in      = 1'($urandom);
      mode      = 1'($urandom);
      step();
      if (acc) sent++;
    end
    check("rand_sent", sent, 10000);
    drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
